// File: rtl/axi4_mult_slave.sv
// rtl/axi4_mult_slave.sv - AXI4-style slave: byte-beat operand writes, shift-add multiply, burst readback
//
// Ports:
//   clk, _rst                 clock; asynchronous active-low reset
//   aw*/w*/b*                 operand write channel (awaddr 0 = a, 1 = b), byte beats LSB first
//   ar*/r*                    result read channel (araddr 0 = low half, 1 = high half), byte beats LSB first
//   res                       current 2*SZ-bit product register
//   busy                      multiplier running
//   done                      one-cycle pulse when res updates
module axi4_mult_slave #(
    parameter int SZ  = 32,
    parameter int ASZ = 2,
    parameter int DSZ = 8
) (
    input  logic            clk,
    input  logic            _rst,
    input  logic [ASZ-1:0]  awaddr,
    input  logic            awvalid,
    output logic            awready,
    input  logic [DSZ-1:0]  wdata,
    input  logic            wvalid,
    output logic            wready,
    input  logic            wlast,
    output logic            bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ASZ-1:0]  araddr,
    input  logic            arvalid,
    output logic            arready,
    output logic [DSZ-1:0]  rdata,
    output logic            rvalid,
    input  logic            rready,
    output logic            rlast,
    output logic            rresp,
    output logic [2*SZ-1:0] res,
    output logic            busy,
    output logic            done
);
    localparam int BEATS = SZ / DSZ;
    localparam int LW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // One extra count so beats past the operand width can be detected.
    localparam int CW    = $clog2(BEATS + 1);
    localparam int MW    = (SZ > 1) ? $clog2(SZ) : 1;

    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {M_IDLE, M_RUN}          m_state_t;
    typedef enum logic       {R_ADDR, R_DATA}         r_state_t;

    w_state_t        w_state, w_next;
    m_state_t        m_state, m_next;
    r_state_t        r_state, r_next;

    logic [ASZ-1:0]  w_addr;
    logic [CW-1:0]   w_cnt;
    logic            w_err, bresp_q;
    logic [SZ-1:0]   a_q, b_q;
    logic            a_vld, b_vld;
    logic            w_fire, w_addr_ok, w_beat_ok, w_ok_now;
    logic [LW-1:0]   w_lane;

    logic            m_start;
    logic [MW-1:0]   m_cnt;
    logic [2*SZ-1:0] m_cand, m_acc, m_sum;
    logic [SZ-1:0]   m_plier;

    logic            r_live, r_err;
    logic [LW-1:0]   r_cnt;
    logic [SZ-1:0]   r_buf;

    // ---------------- write path ----------------
    assign w_fire    = (w_state == W_DATA) & wvalid;
    assign w_addr_ok = (w_addr == ASZ'(0)) || (w_addr == ASZ'(1));
    assign w_beat_ok = (w_cnt < CW'(BEATS));
    assign w_lane    = w_cnt[LW-1:0];
    // Response status must include the error status of the wlast beat itself.
    assign w_ok_now  = ~w_err & w_addr_ok & w_beat_ok;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) w_state <= W_ADDR;
        else       w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 1'b0;
        case (w_state)
            W_ADDR: begin
                awready = 1'b1;
                if (awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = bresp_q;
                if (bready) w_next = W_ADDR;
            end
            default: w_next = W_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            w_addr  <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bresp_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_vld   <= 1'b0;
            b_vld   <= 1'b0;
        end else begin
            // Clear first so a burst completing on the start edge re-arms the flag.
            if (m_start) begin
                a_vld <= 1'b0;
                b_vld <= 1'b0;
            end
            if (w_state == W_ADDR && awvalid) begin
                w_addr <= awaddr;
                w_cnt  <= '0;
                w_err  <= 1'b0;
            end
            if (w_fire) begin
                if (w_addr_ok && w_beat_ok) begin
                    if (w_addr == ASZ'(0)) a_q[w_lane*DSZ +: DSZ] <= wdata;
                    else                   b_q[w_lane*DSZ +: DSZ] <= wdata;
                end else begin
                    w_err <= 1'b1;
                end
                // Saturate so arbitrarily long bursts stay flagged as overrun.
                if (w_beat_ok) w_cnt <= w_cnt + CW'(1);
                if (wlast) begin
                    bresp_q <= w_ok_now;
                    if (w_ok_now) begin
                        if (w_addr == ASZ'(0)) a_vld <= 1'b1;
                        else                   b_vld <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- multiplier ----------------
    assign m_start = (m_state == M_IDLE) & a_vld & b_vld;
    assign m_sum   = m_acc + (m_plier[0] ? m_cand : '0);

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) m_state <= M_IDLE;
        else       m_state <= m_next;
    end

    always_comb begin
        m_next = m_state;
        busy   = 1'b0;
        case (m_state)
            M_IDLE: if (a_vld && b_vld) m_next = M_RUN;
            M_RUN: begin
                busy = 1'b1;
                if (m_cnt == MW'(SZ - 1)) m_next = M_IDLE;
            end
            default: m_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            m_cnt   <= '0;
            m_cand  <= '0;
            m_acc   <= '0;
            m_plier <= '0;
            res     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (m_start) begin
                m_cand  <= {{SZ{1'b0}}, a_q};
                m_plier <= b_q;
                m_acc   <= '0;
                m_cnt   <= '0;
            end else if (m_state == M_RUN) begin
                m_acc   <= m_sum;
                m_cand  <= m_cand << 1;
                m_plier <= m_plier >> 1;
                m_cnt   <= m_cnt + MW'(1);
                if (m_cnt == MW'(SZ - 1)) begin
                    res  <= m_sum;
                    done <= 1'b1;
                end
            end
        end
    end

    // ---------------- read path ----------------
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) r_state <= R_ADDR;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 1'b0;
        rdata   = '0;
        case (r_state)
            R_ADDR: begin
                // Held off while busy so a read never sees a half-updated result.
                arready = r_live & ~busy;
                if (arvalid && arready) r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rresp  = ~r_err;
                rlast  = r_err | (r_cnt == LW'(BEATS - 1));
                if (!r_err) rdata = r_buf[r_cnt*DSZ +: DSZ];
                if (rready && rlast) r_next = R_ADDR;
            end
            default: r_next = R_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_live <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_buf  <= '0;
        end else begin
            // Keeps arready low while in reset and on the first edge out of it.
            r_live <= 1'b1;
            if (r_state == R_ADDR && arvalid && arready) begin
                r_err <= ~((araddr == ASZ'(0)) || (araddr == ASZ'(1)));
                r_cnt <= '0;
                r_buf <= araddr[0] ? res[2*SZ-1:SZ] : res[SZ-1:0];
            end else if (r_state == R_DATA && rready && !rlast) begin
                r_cnt <= r_cnt + LW'(1);
            end
        end
    end
endmodule

// File: tb/tb_axi4_mult_slave.sv
// tb/tb_axi4_mult_slave.sv - self-checking bench for axi4_mult_slave
module tb_axi4_mult_slave;
    localparam int SZ  = 32;
    localparam int ASZ = 2;
    localparam int DSZ = 8;

    logic            clk = 1'b0;
    logic            _rst;
    logic [ASZ-1:0]  awaddr;
    logic            awvalid, awready;
    logic [DSZ-1:0]  wdata;
    logic            wvalid, wready, wlast;
    logic            bresp, bvalid, bready;
    logic [ASZ-1:0]  araddr;
    logic            arvalid, arready;
    logic [DSZ-1:0]  rdata;
    logic            rvalid, rready, rlast, rresp;
    logic [2*SZ-1:0] res;
    logic            busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_w_edge = 0;
    int done_cnt    = 0;
    int d0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       resp;
    } rbeat_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] r;
    } vec_t;

    rbeat_t rq[$];
    logic   bq[$];
    vec_t   vecs[5];

    axi4_mult_slave #(.SZ(SZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
        .clk(clk), ._rst(_rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .res(res), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; last_w_edge = edge number of the latest wlast handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wvalid && wready && wlast) last_w_edge <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input int n, input logic [63:0] bytes_le, input logic exp_bresp);
        int t;
        bq.push_back(exp_bresp);
        @(negedge clk);
        awaddr  = addr;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        chk("aw_timeout", t < 100, 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wdata  = bytes_le[8*i +: 8];
            wvalid = 1'b1;
            wlast  = (i == n - 1);
            t = 0;
            while (!wready && t < 100) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        chk("b_timeout", t < 100, 1);
        chk("bresp", bresp, bq.pop_front());
        @(negedge clk);
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
    endtask

    task automatic rd(input logic [1:0] addr, input logic [63:0] exp_res);
        int t;
        logic [31:0] half;
        rbeat_t e;
        if (addr > 2'd1) begin
            e.data = 8'h00; e.last = 1'b1; e.resp = 1'b0;
            rq.push_back(e);
        end else begin
            half = addr[0] ? exp_res[63:32] : exp_res[31:0];
            for (int i = 0; i < 4; i++) begin
                e.data = half[8*i +: 8]; e.last = (i == 3); e.resp = 1'b1;
                rq.push_back(e);
            end
        end
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        chk("ar_timeout", t < 200, 1);
        @(negedge clk);
        arvalid = 1'b0;
        t = 0;
        while (rq.size() > 0 && t < 100) begin
            rready = ($urandom_range(0, 3) != 0);
            #1;
            if (rvalid && rready) begin
                e = rq.pop_front();
                chk("rdata", rdata, e.data);
                chk("rlast", rlast, e.last);
                chk("rresp", rresp, e.resp);
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        chk("r_drained", rq.size(), 0);
        chk("rvalid_clear", rvalid, 0);
        rq.delete();
    endtask

    task automatic wait_done(input logic [63:0] exp, input logic chk_lat);
        int t;
        t = 0;
        while (!done && t < 200) begin @(negedge clk); t++; end
        chk("done_timeout", t < 200, 1);
        chk("res", res, exp);
        if (chk_lat) chk("latency", cyc - last_w_edge, SZ + 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h00010002, 32'h00030004, 64'h00000003000A0008};
        vecs[1] = '{32'h00000000, 32'h12345678, 64'h0000000000000000};
        vecs[2] = '{32'h00000001, 32'hFFFFFFFF, 64'h00000000FFFFFFFF};
        vecs[3] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
        vecs[4] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001};

        _rst = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; wlast = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_res", res, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        _rst = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[k]) begin
            wr(2'd0, 4, {32'h0, vecs[k].a}, 1'b1);
            wr(2'd1, 4, {32'h0, vecs[k].b}, 1'b1);
            wait_done(vecs[k].r, 1'b1);
            rd(2'd0, vecs[k].r);
            rd(2'd1, vecs[k].r);
        end

        rd(2'd2, 64'h0);
        rd(2'd3, 64'h0);

        // Read requested during a run waits for the result; a write mid-run arms the next job.
        wr(2'd0, 4, 64'hFFFFFFFF, 1'b1);
        wr(2'd1, 4, 64'hFFFFFFFF, 1'b1);
        chk("busy_running", busy, 1);
        chk("arready_busy", arready, 0);
        wr(2'd0, 4, 64'h2, 1'b1);
        chk("busy_still", busy, 1);
        rd(2'd1, 64'hFFFFFFFE00000001);
        chk("res_ff", res, 64'hFFFFFFFE00000001);
        rd(2'd0, 64'hFFFFFFFE00000001);
        wr(2'd1, 4, 64'h3, 1'b1);
        wait_done(64'h6, 1'b1);

        // Invalid write addresses leave operands and flags alone.
        wr(2'd0, 4, 64'h5, 1'b1);
        wr(2'd2, 4, 64'hFFFFFFFF, 1'b0);
        wr(2'd3, 1, 64'hFF, 1'b0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_calc_bad_addr", done_cnt, d0);
        wr(2'd1, 4, 64'h7, 1'b1);
        wait_done(64'h23, 1'b1);

        // Overlong burst writes bytes 0-3 only and does not arm; short burst keeps upper byte.
        wr(2'd1, 4, 64'h3, 1'b1);
        wr(2'd0, 5, 64'h99AABBCCDD, 1'b0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_calc_overrun", done_cnt, d0);
        wr(2'd0, 3, 64'h332211, 1'b1);
        wait_done(64'h00000001FE996633, 1'b1);

        // Reset mid-burst while a computation runs and b is armed.
        wr(2'd0, 4, 64'h2, 1'b1);
        wr(2'd1, 4, 64'h9, 1'b1);
        wr(2'd1, 4, 64'h9, 1'b1);
        @(negedge clk);
        awaddr = 2'd0; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wdata = 8'h12; wvalid = 1'b1; wlast = 1'b0;
        @(negedge clk);
        wdata = 8'h34;
        @(negedge clk);
        wvalid = 1'b0;
        #2 _rst = 1'b0;
        #1;
        chk("mid_rst_awready", awready, 1);
        chk("mid_rst_wready", wready, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_res", res, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        _rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);
        chk("post_rst_bvalid", bvalid, 0);
        wr(2'd0, 4, 64'h2, 1'b1);
        d0 = done_cnt;
        repeat (45) @(negedge clk);
        chk("no_calc_after_rst", done_cnt, d0);
        chk("res_after_rst", res, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_mult_slave.md
Name: axi4_mult_slave

Overview:
AXI4-style slave that sits directly downstream of the operand-writing AXI4 master. It receives two SZ-bit operands as byte-beat write bursts and computes their 2*SZ-bit product with a sequential shift-add multiplier. The result is returned over AR/R bursts and is also presented on a flat res port.

Parameters:
SZ, 32, operand width in bits; product is 2*SZ.
ASZ, 2, address width of AW/AR.
DSZ, 8, data beat width; BEATS = SZ/DSZ (4 at defaults).

Ports:
clk  input  1  clock.
_rst  input  1  reset.
awaddr  input  ASZ  0 = operand a, 1 = operand b, others invalid.
awvalid  input  1  write address valid.
awready  output  1  write address ready.
wdata  input  DSZ  write beat data, least-significant byte first.
wvalid  input  1  write beat valid.
wready  output  1  write beat ready.
wlast  input  1  last beat of burst.
bresp  output  1  1 = ok, 0 = error.
bvalid  output  1  write response valid.
bready  input  1  write response ready.
araddr  input  ASZ  0 = res[SZ-1:0], 1 = res[2SZ-1:SZ], others invalid.
arvalid  input  1  read address valid.
arready  output  1  read address ready.
rdata  output  DSZ  read beat data, least-significant byte first.
rvalid  output  1  read beat valid.
rready  input  1  read beat ready.
rlast  output  1  last read beat.
rresp  output  1  1 = ok, 0 = error.
res  output  2*SZ  current product register.
busy  output  1  multiplier running.
done  output  1  one-cycle pulse when res updates.

Behaviour:
- Reset: _rst is asynchronous, active-low; clk is the clock.
  - All outputs 0 except awready = 1.
  - Operand registers, valid flags, res and counters cleared; all FSMs return to idle.
  - Reset mid-burst abandons the burst; no response is issued.
- Write FSM states: W_ADDR, W_DATA, W_RESP.
  - W_ADDR: awready = 1. On awvalid & awready, latch awaddr, clear beat counter and error flag, go to W_DATA (awready = 0, wready = 1).
  - W_DATA: each wvalid & wready beat writes wdata into byte lane [beat] of the selected operand; beat counter increments.
  - Bytes not written in a burst keep their previous value (a 3-beat burst updates bytes 0-2 only).
  - A beat with index >= BEATS is discarded and sets the error flag.
  - An invalid awaddr discards all beats and sets the error flag.
  - On the wlast beat: wready = 0, bvalid = 1, bresp = !error, go to W_RESP.
  - If bresp = 1, set a_vld or b_vld at that same edge.
  - W_RESP: hold bvalid/bresp until bready. Then bvalid = 0, awready = 1, return to W_ADDR.
  - The write path runs regardless of busy.
- Multiplier FSM states: M_IDLE, M_RUN.
  - In M_IDLE, when a_vld & b_vld: snapshot a and b, clear both flags, clear the accumulator, busy = 1, enter M_RUN.
  - M_RUN does one shift-add iteration per cycle for SZ cycles.
  - On the last iteration edge: res takes the full 2*SZ product (unsigned, no truncation), busy = 0, done = 1 for one cycle, return to M_IDLE.
  - Latency: flag-setting edge t -> M_RUN at edge t+1 -> res/done at edge t+1+SZ.
  - Operand writes during M_RUN do not disturb the snapshot; they arm the next computation.
- Read FSM states: R_ADDR, R_DATA.
  - arready = 1 only in R_ADDR with busy = 0, so reads never observe a partial result.
  - araddr 0/1: BEATS beats of the selected res half, byte 0 first, rresp = 1, rlast on beat BEATS-1.
  - Invalid araddr: a single beat, rdata = 0, rresp = 0, rlast = 1.
  - rvalid/rdata/rlast are held until rready; the next beat is presented on the following cycle.
  - After the rlast handshake, return to R_ADDR.
- Read and write FSMs are independent and may be active in the same cycle.

Test Plan:
- Write a = 0x00010002 (bytes 02,00,01,00) then b = 0x00030004, both bresp = 1 -> done pulses SZ+1 cycles after b's last beat; res = 0x00000003000A0008.
- Then read araddr 0 then araddr 1 -> rdata 08,00,0A,00 with rlast on beat 4, then 03,00,00,00; rresp = 1 on all beats.
- a = b = 0xFFFFFFFF -> res = 0xFFFFFFFE00000001; issue arvalid while busy -> arready = 0 until done, then the read succeeds.
- Write awaddr 2 with 4 beats -> bresp = 0, operands and flags unchanged, no computation starts.
- Write a 5-beat burst to a -> bresp = 0, only bytes 0-3 are written, a_vld is not set.
- Write a with wlast on beat 3 (a previously 0xAABBCCDD; new bytes 11,22,33) -> a = 0xAA332211, bresp = 1.
- Assert _rst mid-burst -> awready = 1, bvalid = 0, res = 0, busy = 0, all flags cleared.
